// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM encodings (boot, run, fault)
//   NOP_INSTR     : word presented to decode while the buffer is empty
//   *_LSB/*_MSB   : bit positions of the op/func3/func7 decode fields
//   sat_add32     : saturating 32-bit add used by the optional perf counters
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned OP_LSB    = 0;
  localparam int unsigned OP_MSB    = 6;
  localparam int unsigned FUNC3_LSB = 12;
  localparam int unsigned FUNC3_MSB = 14;
  localparam int unsigned FUNC7_LSB = 25;
  localparam int unsigned FUNC7_MSB = 31;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs.
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   i_push        : write i_push_data (accepted when not full, or full with a pop)
//   i_pop         : drop the head entry (ignored when empty)
//   i_flush       : empty the FIFO; overrides push and pop
//   o_head        : combinational head entry
//   o_count       : number of valid entries
//   o_empty       : no valid entries
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic [CntW-1:0]  o_count,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_rd;
  logic [PtrW-1:0]  r_wr;
  logic [CntW-1:0]  r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != CntW'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PtrW'(1);
      if (w_pop)  r_rd <= r_rd + PtrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !i_flush && w_push) r_mem[r_wr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the decode controller.
// Optional feature: define FETCH_PERF_EN to add perf_fetched / perf_discarded counters.
// Ports:
//   clk, rst                      : rising-edge clock, synchronous active-high reset
//   imem_req_valid/ready/addr     : word-aligned fetch request channel
//   imem_rsp_valid/data           : in-order response channel, always accepted
//   redirect, redirect_pc         : jump/taken-branch redirect pulse and target
//   instr_valid/ready             : head instruction handshake with decode
//   instr, instr_pc, instr_pc_plus4 : head word (NOP when empty), its PC, PC + 4
//   op, func3, func7              : decode slices of instr
//   fetch_fault                   : misaligned redirect target pending
//   perf_fetched, perf_discarded  : (FETCH_PERF_EN only) saturating event counters
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  output logic [6:0]      op,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic            fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_discarded
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_state_e      r_state, w_state_next;
  logic [XLEN-1:0]   r_fetch_pc, w_fetch_pc_next;
  logic [CntW-1:0]   r_outstanding, w_outstanding_next;
  logic [CntW-1:0]   r_discard, w_discard_next;

  // PCs of in-flight requests, oldest first; always holds r_outstanding entries.
  logic [XLEN-1:0]   r_pcq [DEPTH];
  logic [PtrW-1:0]   r_pcq_wr;
  logic [PtrW-1:0]   r_pcq_rd;

  logic              w_hs;
  logic              w_rsp;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_credit_ok;
  logic [CntW:0]     w_inflight;
  logic [CntW-1:0]   w_fifo_count;
  logic              w_fifo_empty;
  logic [2*XLEN-1:0] w_head;

  // Responses with nothing outstanding only come from memory that was not reset.
  assign w_rsp       = imem_rsp_valid && (r_outstanding != '0);
  assign w_inflight  = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign w_credit_ok = w_inflight < (CntW + 1)'(DEPTH);

  assign imem_req_valid = (r_state == FETCH_RUN) && !redirect && w_credit_ok;
  assign imem_req_addr  = r_fetch_pc;
  assign w_hs           = imem_req_valid && imem_req_ready;

  // A response landing on the redirect cycle is stale by definition.
  assign w_drop = imem_rsp_valid && ((r_discard != '0) || redirect);
  assign w_push = imem_rsp_valid && !w_drop;
  assign w_pop  = instr_valid && instr_ready && !redirect;

  always_comb begin
    w_state_next       = r_state;
    w_fetch_pc_next    = r_fetch_pc;
    w_outstanding_next = r_outstanding + CntW'(w_hs) - CntW'(w_rsp);
    w_discard_next     = r_discard - CntW'(w_rsp && (r_discard != '0));

    unique case (r_state)
      FETCH_BOOT:  w_state_next = FETCH_RUN;
      FETCH_RUN:   w_state_next = FETCH_RUN;
      FETCH_FAULT: w_state_next = FETCH_FAULT;
      default:     w_state_next = FETCH_BOOT;
    endcase

    if (w_hs) w_fetch_pc_next = r_fetch_pc + XLEN'(4);

    if (redirect) begin
      w_fetch_pc_next = redirect_pc;
      // Everything still in flight after this cycle belongs to the old path.
      w_discard_next  = r_outstanding - CntW'(w_rsp) + CntW'(w_hs);
      w_state_next    = (redirect_pc[1:0] != 2'b00) ? FETCH_FAULT : FETCH_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FETCH_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_pcq_wr      <= '0;
      r_pcq_rd      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_fetch_pc    <= w_fetch_pc_next;
      r_outstanding <= w_outstanding_next;
      r_discard     <= w_discard_next;
      if (w_hs)  r_pcq_wr <= r_pcq_wr + PtrW'(1);
      if (w_rsp) r_pcq_rd <= r_pcq_rd + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_hs) r_pcq[r_pcq_wr] <= r_fetch_pc;
  end

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({r_pcq[r_pcq_rd], imem_rsp_data}),
    .i_pop       (w_pop),
    .i_flush     (redirect),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty)
  );

  assign instr_valid    = !w_fifo_empty;
  assign instr          = w_fifo_empty ? XLEN'(NOP_INSTR) : w_head[XLEN-1:0];
  assign instr_pc       = w_head[2*XLEN-1:XLEN];
  assign instr_pc_plus4 = instr_pc + XLEN'(4);
  assign op             = instr[OP_MSB:OP_LSB];
  assign func3          = instr[FUNC3_MSB:FUNC3_LSB];
  assign func7          = instr[FUNC7_MSB:FUNC7_LSB];
  assign fetch_fault    = (r_state == FETCH_FAULT);

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_discarded;
  logic [31:0] w_discard_inc;

  // Dropped response plus every entry thrown away by a flush.
  assign w_discard_inc = 32'(w_drop) + (redirect ? 32'(w_fifo_count) : 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched   <= '0;
      r_perf_discarded <= '0;
    end else begin
      r_perf_fetched   <= sat_add32(r_perf_fetched, 32'(w_pop));
      r_perf_discarded <= sat_add32(r_perf_discarded, w_discard_inc);
    end
  end

  assign perf_fetched   = r_perf_fetched;
  assign perf_discarded = r_perf_discarded;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected PCs, monitors compare pops.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready, fetch_fault;
  logic [31:0] instr, instr_pc, instr_pc_plus4;
  logic [6:0]  op, func7;
  logic [2:0]  func3;

  logic        w_req_valid, w_req_ready, w_rsp_valid;
  logic [31:0] w_req_addr, w_rsp_data;
  logic        w_instr_valid, w_instr_ready, w_fault;
  logic [31:0] w_instr, w_instr_pc, w_instr_pc_plus4;
  logic [6:0]  w_op, w_func7;
  logic [2:0]  w_func3;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] w_exp_q [$];
  int          w_left = 4;
  logic [31:0] next_pc;
  logic        mem_hold;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk (clk), .rst (rst),
    .imem_req_valid (imem_req_valid), .imem_req_ready (imem_req_ready),
    .imem_req_addr (imem_req_addr), .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data), .redirect (redirect), .redirect_pc (redirect_pc),
    .instr_valid (instr_valid), .instr_ready (instr_ready), .instr (instr),
    .instr_pc (instr_pc), .instr_pc_plus4 (instr_pc_plus4), .op (op),
    .func3 (func3), .func7 (func7), .fetch_fault (fetch_fault)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk (clk), .rst (rst),
    .imem_req_valid (w_req_valid), .imem_req_ready (w_req_ready),
    .imem_req_addr (w_req_addr), .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data (w_rsp_data), .redirect (1'b0), .redirect_pc (32'h0),
    .instr_valid (w_instr_valid), .instr_ready (w_instr_ready), .instr (w_instr),
    .instr_pc (w_instr_pc), .instr_pc_plus4 (w_instr_pc_plus4), .op (w_op),
    .func3 (w_func3), .func7 (w_func7), .fetch_fault (w_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0033;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Memory model: accepts every request, answers one cycle later unless held.
  initial begin : mem_main
    logic [31:0] pend [$];
    logic        m_hs, m_hold, m_rst;
    logic [31:0] m_addr;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      m_hs   = imem_req_valid && imem_req_ready;
      m_addr = imem_req_addr;
      m_hold = mem_hold;
      m_rst  = rst;
      @(posedge clk);
      #1;
      if (m_rst) begin
        pend.delete();
        imem_rsp_valid = 1'b0;
      end else begin
        if (m_hs) pend.push_back(m_addr);
        if (!m_hold && pend.size() != 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
        end
      end
    end
  end

  initial begin : mem_wrap
    logic [31:0] pend [$];
    logic        m_hs, m_rst;
    logic [31:0] m_addr;
    w_req_ready = 1'b1;
    w_rsp_valid = 1'b0;
    w_rsp_data  = '0;
    forever begin
      @(negedge clk);
      m_hs   = w_req_valid && w_req_ready;
      m_addr = w_req_addr;
      m_rst  = rst;
      @(posedge clk);
      #1;
      if (m_rst) begin
        pend.delete();
        w_rsp_valid = 1'b0;
      end else begin
        if (m_hs) pend.push_back(m_addr);
        if (pend.size() != 0) begin
          w_rsp_valid = 1'b1;
          w_rsp_data  = mem_word(pend.pop_front());
        end else begin
          w_rsp_valid = 1'b0;
        end
      end
    end
  end

  // Main monitor: every accepted head instruction is checked against the scoreboard.
  initial begin : mon_main
    logic [31:0] e;
    logic [31:0] ei;
    forever begin
      @(negedge clk);
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop_pc", instr_pc, 32'hxxxx_xxxx);
        end else begin
          e  = exp_q.pop_front();
          ei = mem_word(e);
          check("pop_pc", instr_pc, e);
          check("pop_instr", instr, ei);
          check("pop_pc_plus4", instr_pc_plus4, e + 32'd4);
          check("pop_op", 32'(op), 32'(ei[6:0]));
          check("pop_func3", 32'(func3), 32'(ei[14:12]));
          check("pop_func7", 32'(func7), 32'(ei[31:25]));
        end
      end
    end
  end

  initial begin : mon_wrap
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (w_instr_valid && w_instr_ready && w_exp_q.size() != 0) begin
        e = w_exp_q.pop_front();
        check("wrap_pc", w_instr_pc, e);
        check("wrap_instr", w_instr, mem_word(e));
        check("wrap_pc_plus4", w_instr_pc_plus4, e + 32'd4);
        w_left--;
      end
    end
  end

  initial begin : wrap_ready
    w_instr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      w_instr_ready = (w_left > 0) && !rst;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(next_pc);
      next_pc += 32'd4;
    end
  endtask

  task automatic drain(input int n);
    int cnt = 0;
    int cyc = 0;
    @(posedge clk);
    #1 instr_ready = 1'b1;
    while (cnt < n && cyc < 60) begin
      @(negedge clk);
      if (instr_valid && instr_ready && !redirect) cnt++;
      cyc++;
    end
    @(posedge clk);
    #1 instr_ready = 1'b0;
    check("drain_pop_count", cnt, n);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = pc;
    @(posedge clk);
    #1 redirect = 1'b0;
  endtask

  initial begin : stim
    int bp_hs;
    int f_hs;
    logic hit;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    mem_hold    = 1'b0;
    next_pc     = 32'h0;
    w_exp_q.push_back(32'hFFFF_FFF8);
    w_exp_q.push_back(32'hFFFF_FFFC);
    w_exp_q.push_back(32'h0000_0000);
    w_exp_q.push_back(32'h0000_0004);

    // Reset, then the single BOOT cycle with no request.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("boot_req_valid", 32'(imem_req_valid), 32'd0);
    check("reset_instr_valid", 32'(instr_valid), 32'd0);
    check("reset_fetch_fault", 32'(fetch_fault), 32'd0);
    check("reset_instr_nop", instr, 32'h0000_0013);
    check("reset_op", 32'(op), 32'h13);
    @(negedge clk);
    check("run_req_valid", 32'(imem_req_valid), 32'd1);
    check("run_req_addr", imem_req_addr, 32'h0);

    // Stream 0x0, 0x4, 0x8.
    push_exp(3);
    drain(3);

    // Backpressure: credit limit caps requests while decode stalls.
    bp_hs = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) bp_hs++;
    end
    check("bp_issue_le_depth", (bp_hs <= 2) ? 32'd1 : 32'd0, 32'd1);
    check("bp_fifo_full_valid", 32'(instr_valid), 32'd1);
    push_exp(4);
    drain(4);

    // Redirect with two requests held in memory.
    repeat (4) @(posedge clk);
    #1 mem_hold = 1'b1;
    push_exp(2);
    drain(2);
    repeat (4) @(negedge clk);
    check("held_credit_block", 32'(imem_req_valid), 32'd0);
    do_redirect(32'h0000_0100);
    mem_hold = 1'b0;
    next_pc  = 32'h0000_0100;
    push_exp(3);
    drain(3);

    // Redirect coinciding with a response and a pop.
    push_exp(6);
    @(posedge clk);
    #1 instr_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(posedge clk);
      #2;
      if (imem_rsp_valid && instr_valid) begin
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0180;
        hit         = 1'b1;
      end
    end
    check("simul_event_found", 32'(hit), 32'd1);
    @(posedge clk);
    #1 redirect = 1'b0;
    exp_q.delete();
    next_pc = 32'h0000_0180;
    @(negedge clk);
    check("simul_fifo_empty", 32'(instr_valid), 32'd0);
    check("simul_instr_nop", instr, 32'h0000_0013);
    push_exp(3);
    drain(3);

    // Misaligned redirect, then recovery to an aligned target.
    do_redirect(32'h0000_0102);
    exp_q.delete();
    @(negedge clk);
    check("fault_set", 32'(fetch_fault), 32'd1);
    check("fault_instr_valid", 32'(instr_valid), 32'd0);
    f_hs = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_req_valid) f_hs++;
    end
    check("fault_no_requests", f_hs, 0);
    check("fault_held", 32'(fetch_fault), 32'd1);
    do_redirect(32'h0000_0200);
    @(negedge clk);
    check("recover_fault_clear", 32'(fetch_fault), 32'd0);
    check("recover_req_valid", 32'(imem_req_valid), 32'd1);
    check("recover_req_addr", imem_req_addr, 32'h0000_0200);
    next_pc = 32'h0000_0200;
    push_exp(2);
    drain(2);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("wrap_all_popped", w_left, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
